fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequencer for the IF-stage PC register; drives its start, stallF, flushF, pc_restore and pc_next inputs.
- Takes the register's pc_out back as pc_cur.
- Runs the boot hold, the instruction-memory request/acknowledge handshake, hazard stalls and branch/jump redirects.
- Sits between the hazard unit / EX-stage redirect logic and the instruction memory; presents fetched instructions to IF/ID with a valid flag.

Parameters:
- BOOT_CYCLES, 4: cycles start is held high after reset (legal range 1..255).
- RESET_PC, 32'h0000_0000: PC loaded via flush at end of boot.
- PC_STEP, 4: sequential PC increment.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_hz  in  1  hazard-unit stall request for the fetch stage.
- redirect_valid  in  1  branch/jump taken; one-cycle pulse.
- redirect_pc  in  32  redirect target; valid with redirect_valid.
- pc_cur  in  32  current PC fed back from the PC register.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  request address; equals pc_cur.
- imem_ack  in  1  memory response valid; at most one per request.
- imem_rdata  in  32  instruction word; valid with imem_ack.
- start  out  1  to PC register; holds the PC.
- stallF  out  1  to PC register; holds the PC.
- flushF  out  1  to PC register; loads pc_restore.
- pc_restore  out  32  PC load value.
- pc_next  out  32  sequential PC.
- instr_valid  out  1  instr_out is valid for IF/ID this cycle.
- instr_out  out  32  fetched instruction, equal to imem_rdata.
- boot_done  out  1  high once the boot and INIT states have completed.

Behaviour:
- FSM states: BOOT, INIT, FETCH, WAIT. Registers: state, 8-bit boot counter, pend flag, pend_pc[31:0].
- Reset (rst=1 at edge): state=BOOT, counter=BOOT_CYCLES-1, pend=0, pend_pc=0.
- Reset applies in any state, mid-transaction included. An ack arriving after reset is ignored: in BOOT/INIT, imem_ack is don't-care.
- Output values while in BOOT after reset: start=1, imem_req=0, flushF=0, stallF=0, instr_valid=0, boot_done=0, pc_restore=RESET_PC.
- All outputs are combinational from state/registers/inputs; no output is registered.
- pc_next = pc_cur + PC_STEP, modulo 2^32 (32'hFFFF_FFFC + 4 wraps to 0).
- BOOT:
  - start=1.
  - Counter decrements each cycle; at 0, go to INIT.
  - start is high for exactly BOOT_CYCLES cycles.
  - redirect_valid and stall_hz are ignored.
- INIT: one cycle, start=0, flushF=1, pc_restore=RESET_PC; then FETCH. boot_done=1 from the first FETCH cycle onward.
- FETCH, priority order:
  1. redirect_valid & imem_ack: flushF=1, pc_restore=redirect_pc, instr_valid=0; stay in FETCH.
  2. redirect_valid & !imem_ack & !stall_hz: request is outstanding. stallF=1, pend=1, pend_pc=redirect_pc; go to WAIT.
  3. redirect_valid & stall_hz: imem_req=0, flushF=1, pc_restore=redirect_pc. Redirect beats stall.
  4. stall_hz: imem_req=0, stallF=1, instr_valid=0; refetch next cycle.
  5. Otherwise imem_req=1.
     - imem_ack: instr_valid=1; PC advances (stallF=0, flushF=0).
     - No ack: stallF=1; go to WAIT.
- WAIT:
  - imem_req=1 held; imem_addr stable because the PC is held. stallF=1 unless flushing.
  - redirect_valid without ack: pend=1, pend_pc=redirect_pc. The newest redirect overwrites.
  - On imem_ack:
    - pend or redirect_valid: instr_valid=0, flushF=1, pc_restore = redirect_valid ? redirect_pc : pend_pc; clear pend.
    - Otherwise: instr_valid=1, stallF=stall_hz, so the PC advances only if no hazard.
    - Return to FETCH in both cases.
  - stall_hz does not drop an outstanding request.
- Invariants:
  - flushF and stallF are never both 1.
  - instr_valid=1 only with imem_ack and no pending or current redirect.
  - imem_req is 0 in BOOT/INIT.

Test Plan:
- rst for 2 cycles, then release, BOOT_CYCLES=4 -> start=1 for 4 cycles; INIT cycle with flushF=1, pc_restore=0; first imem_req with imem_addr=0; boot_done=1.
- Zero-wait memory (ack same cycle), 4 fetches -> instr_valid=1 each cycle; imem_addr 0,4,8,C; stallF=0.
- Ack delayed 3 cycles at PC 8 -> WAIT with stallF=1 for 3 cycles, imem_addr stays 8; instr_valid pulses once on ack; next address C.
- In WAIT, redirect to 0x100, then redirect to 0x200 on the next cycle, ack 2 cycles later -> instr_valid=0; flushF=1 with pc_restore=0x200; next imem_addr=0x200.
- stall_hz=1 for 2 cycles in FETCH at PC 0x10 -> imem_req=0, stallF=1, PC stays 0x10; in a separate run, redirect_valid with stall_hz=1 -> flushF=1 with pc_restore=redirect_pc; at PC 0xFFFF_FFFC, pc_next=0.
- rst asserted while in WAIT with pend=1 -> BOOT next cycle; pend cleared; late imem_ack produces instr_valid=0; boot sequence repeats.

Source files
------------

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : IF-stage sequencer. Runs the boot hold, the instruction-memory
//               request/acknowledge handshake, hazard stalls and redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter int unsigned BOOT_CYCLES = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] PC_STEP     = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_hz,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] pc_cur,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        start,
    output logic        stallF,
    output logic        flushF,
    output logic [31:0] pc_restore,
    output logic [31:0] pc_next,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic        boot_done
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_INIT  = 2'd1,
        ST_FETCH = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    localparam logic [7:0] C_BOOT_LAST = 8'(BOOT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  boot_cnt_q, boot_cnt_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= C_BOOT_LAST;
            pend_q     <= 1'b0;
            pend_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            pend_q     <= pend_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        pend_d      = pend_q;
        pend_pc_d   = pend_pc_q;
        start       = 1'b0;
        imem_req    = 1'b0;
        stallF      = 1'b0;
        flushF      = 1'b0;
        pc_restore  = RESET_PC;
        instr_valid = 1'b0;

        case (state_q)
            ST_BOOT: begin
                start = 1'b1;
                if (boot_cnt_q == 8'd0) begin
                    state_d = ST_INIT;
                end else begin
                    boot_cnt_d = boot_cnt_q - 8'd1;
                end
            end

            ST_INIT: begin
                flushF  = 1'b1;
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                if (redirect_valid && imem_ack) begin
                    imem_req   = 1'b1;
                    flushF     = 1'b1;
                    pc_restore = redirect_pc;
                end else if (redirect_valid && !stall_hz) begin
                    // Request is already on the bus; the target waits for its ack.
                    imem_req  = 1'b1;
                    stallF    = 1'b1;
                    pend_d    = 1'b1;
                    pend_pc_d = redirect_pc;
                    state_d   = ST_WAIT;
                end else if (redirect_valid) begin
                    flushF     = 1'b1;
                    pc_restore = redirect_pc;
                end else if (stall_hz) begin
                    stallF = 1'b1;
                end else begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        instr_valid = 1'b1;
                    end else begin
                        stallF  = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_d = ST_FETCH;
                    pend_d  = 1'b0;
                    if (pend_q || redirect_valid) begin
                        flushF     = 1'b1;
                        pc_restore = redirect_valid ? redirect_pc : pend_pc_q;
                    end else begin
                        instr_valid = 1'b1;
                        stallF      = stall_hz;
                    end
                end else begin
                    stallF = 1'b1;
                    if (redirect_valid) begin
                        pend_d    = 1'b1;
                        pend_pc_d = redirect_pc;
                    end
                end
            end

            default: state_d = ST_BOOT;
        endcase
    end

    assign imem_addr = pc_cur;
    assign pc_next   = pc_cur + PC_STEP;
    assign instr_out = imem_rdata;
    assign boot_done = (state_q == ST_FETCH) || (state_q == ST_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Self-checking bench for fetch_ctrl with a PC register, a
//               random-latency memory and a transaction-level fetch model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    localparam int unsigned BOOT_CYCLES = 4;
    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] PC_STEP     = 32'd4;

    logic        clk            = 1'b0;
    logic        rst            = 1'b1;
    logic        stall_hz       = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        imem_ack       = 1'b0;
    logic [31:0] pc_cur;
    logic [31:0] imem_rdata;
    logic        imem_req, start, stallF, flushF, instr_valid, boot_done;
    logic [31:0] imem_addr, pc_restore, pc_next, instr_out;
    logic [5:0]  ctl;
    logic [31:0] pc_reg = 32'hDEAD_BEE0;

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(
        .BOOT_CYCLES (BOOT_CYCLES),
        .RESET_PC    (RESET_PC),
        .PC_STEP     (PC_STEP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_hz       (stall_hz),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc_cur         (pc_cur),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .start          (start),
        .stallF         (stallF),
        .flushF         (flushF),
        .pc_restore     (pc_restore),
        .pc_next        (pc_next),
        .instr_valid    (instr_valid),
        .instr_out      (instr_out),
        .boot_done      (boot_done)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    always #5 clk = ~clk;

    // PC register: start holds, flush loads, stall holds, otherwise advance.
    always @(posedge clk) begin
        if (start)        pc_reg <= pc_reg;
        else if (flushF)  pc_reg <= pc_restore;
        else if (!stallF) pc_reg <= pc_next;
    end

    assign pc_cur     = pc_reg;
    assign imem_rdata = mem_word(imem_addr);
    assign ctl        = {start, imem_req, flushF, stallF, instr_valid, boot_done};

    task automatic drive(input logic r, input logic s, input logic rv, input logic [31:0] rp, input logic a);
        @(negedge clk);
        rst            = r;
        stall_hz       = s;
        redirect_valid = rv;
        redirect_pc    = rp;
        imem_ack       = a;
        #1;
    endtask

    task automatic set_pc(input logic [31:0] pc);
        drive(1'b0, 1'b0, 1'b1, pc, 1'b1);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < int'(BOOT_CYCLES); i++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h4000, 1'($urandom_range(0, 1)));
            checks++; if ({ctl, pc_restore} !== {6'b100000, RESET_PC}) begin errors++; $display("FAIL reset_boot[%0d]: ctl=%b pc_restore=%h, want ctl=100000 pc_restore=%h", i, ctl, pc_restore, RESET_PC); end
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if ({ctl, pc_restore} !== {6'b001000, RESET_PC}) begin errors++; $display("FAIL reset_init: ctl=%b pc_restore=%h, want ctl=001000 pc_restore=%h", ctl, pc_restore, RESET_PC); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] ea;
        for (int i = 0; i < 4; i++) begin
            ea = RESET_PC + 32'(i) * PC_STEP;
            drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            checks++; if ({ctl, imem_addr} !== {6'b010011, ea}) begin errors++; $display("FAIL zero_wait[%0d]: ctl=%b addr=%h, want ctl=010011 addr=%h", i, ctl, imem_addr, ea); end
            checks++; if (instr_out !== mem_word(ea)) begin errors++; $display("FAIL zero_wait_data[%0d]: got %h want %h", i, instr_out, mem_word(ea)); end
        end
    endtask

    task automatic test_delayed_ack();
        set_pc(32'h8);
        checks++; if ({ctl, pc_restore} !== {6'b011001, 32'h8}) begin errors++; $display("FAIL fetch_redirect_ack: ctl=%b pc_restore=%h, want ctl=011001 pc_restore=00000008", ctl, pc_restore); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            checks++; if ({ctl, imem_addr} !== {6'b010101, 32'h8}) begin errors++; $display("FAIL delayed_wait[%0d]: ctl=%b addr=%h, want ctl=010101 addr=00000008", i, ctl, imem_addr); end
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checks++; if ({ctl, instr_out} !== {6'b010011, mem_word(32'h8)}) begin errors++; $display("FAIL delayed_ack: ctl=%b instr=%h, want ctl=010011 instr=%h", ctl, instr_out, mem_word(32'h8)); end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checks++; if ({ctl, imem_addr} !== {6'b010011, 32'hC}) begin errors++; $display("FAIL delayed_next: ctl=%b addr=%h, want ctl=010011 addr=0000000c", ctl, imem_addr); end
    endtask

    task automatic test_wait_redirect();
        set_pc(32'h40);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
        checks++; if ({ctl, imem_addr} !== {6'b010101, 32'h40}) begin errors++; $display("FAIL wr_first: ctl=%b addr=%h, want ctl=010101 addr=00000040", ctl, imem_addr); end
        drive(1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if ({ctl, imem_addr} !== {6'b010101, 32'h40}) begin errors++; $display("FAIL wr_hold: ctl=%b addr=%h, want ctl=010101 addr=00000040", ctl, imem_addr); end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checks++; if ({ctl, pc_restore} !== {6'b011001, 32'h200}) begin errors++; $display("FAIL wr_flush: ctl=%b pc_restore=%h, want ctl=011001 pc_restore=00000200", ctl, pc_restore); end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checks++; if ({ctl, imem_addr} !== {6'b010011, 32'h200}) begin errors++; $display("FAIL wr_target: ctl=%b addr=%h, want ctl=010011 addr=00000200", ctl, imem_addr); end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h700, 1'b1);
        checks++; if ({ctl, pc_restore} !== {6'b011001, 32'h700}) begin errors++; $display("FAIL wr_ack_redirect: ctl=%b pc_restore=%h, want ctl=011001 pc_restore=00000700", ctl, pc_restore); end
        drive(1'b0, 1'b0, 1'b1, 32'h800, 1'b0);
        checks++; if ({ctl, imem_addr} !== {6'b010101, 32'h700}) begin errors++; $display("FAIL fetch_redirect_pend: ctl=%b addr=%h, want ctl=010101 addr=00000700", ctl, imem_addr); end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checks++; if ({ctl, pc_restore} !== {6'b011001, 32'h800}) begin errors++; $display("FAIL pend_flush: ctl=%b pc_restore=%h, want ctl=011001 pc_restore=00000800", ctl, pc_restore); end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checks++; if ({ctl, imem_addr} !== {6'b010011, 32'h800}) begin errors++; $display("FAIL pend_target: ctl=%b addr=%h, want ctl=010011 addr=00000800", ctl, imem_addr); end
    endtask

    task automatic test_stall();
        set_pc(32'h10);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            checks++; if ({ctl, imem_addr} !== {6'b000101, 32'h10}) begin errors++; $display("FAIL stall[%0d]: ctl=%b addr=%h, want ctl=000101 addr=00000010", i, ctl, imem_addr); end
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checks++; if ({ctl, imem_addr} !== {6'b010011, 32'h10}) begin errors++; $display("FAIL stall_release: ctl=%b addr=%h, want ctl=010011 addr=00000010", ctl, imem_addr); end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        checks++; if ({ctl, imem_addr} !== {6'b010111, 32'h14}) begin errors++; $display("FAIL wait_ack_stall: ctl=%b addr=%h, want ctl=010111 addr=00000014", ctl, imem_addr); end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checks++; if ({ctl, imem_addr} !== {6'b010011, 32'h14}) begin errors++; $display("FAIL refetch: ctl=%b addr=%h, want ctl=010011 addr=00000014", ctl, imem_addr); end
    endtask

    task automatic test_stall_redirect();
        drive(1'b0, 1'b1, 1'b1, 32'h300, 1'b0);
        checks++; if ({ctl, pc_restore} !== {6'b001001, 32'h300}) begin errors++; $display("FAIL stall_redirect: ctl=%b pc_restore=%h, want ctl=001001 pc_restore=00000300", ctl, pc_restore); end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checks++; if ({ctl, imem_addr} !== {6'b010011, 32'h300}) begin errors++; $display("FAIL stall_redirect_tgt: ctl=%b addr=%h, want ctl=010011 addr=00000300", ctl, imem_addr); end
    endtask

    task automatic test_pc_wrap();
        set_pc(32'hFFFF_FFFC);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checks++; if (pc_next !== 32'h0) begin errors++; $display("FAIL pc_wrap: pc_next=%h want 00000000", pc_next); end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checks++; if ({ctl, imem_addr} !== {6'b010011, 32'h0}) begin errors++; $display("FAIL pc_wrap_addr: ctl=%b addr=%h, want ctl=010011 addr=00000000", ctl, imem_addr); end
    endtask

    task automatic test_reset_in_wait();
        set_pc(32'h80);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h500, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (ctl !== 6'b010101) begin errors++; $display("FAIL rst_wait_cycle: ctl=%b want 010101", ctl); end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checks++; if (ctl !== 6'b100000) begin errors++; $display("FAIL rst_late_ack: ctl=%b want 100000", ctl); end
        for (int i = 1; i < int'(BOOT_CYCLES); i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h900, 1'b0);
            checks++; if (ctl !== 6'b100000) begin errors++; $display("FAIL rst_reboot[%0d]: ctl=%b want 100000", i, ctl); end
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if ({ctl, pc_restore} !== {6'b001000, RESET_PC}) begin errors++; $display("FAIL rst_reinit: ctl=%b pc_restore=%h, want ctl=001000 pc_restore=%h", ctl, pc_restore, RESET_PC); end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if ({ctl, imem_addr} !== {6'b010101, RESET_PC}) begin errors++; $display("FAIL rst_refetch: ctl=%b addr=%h, want ctl=010101 addr=%h", ctl, imem_addr, RESET_PC); end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checks++; if ({ctl, instr_out} !== {6'b010011, mem_word(RESET_PC)}) begin errors++; $display("FAIL rst_pend_cleared: ctl=%b instr=%h, want ctl=010011 instr=%h", ctl, instr_out, mem_word(RESET_PC)); end
    endtask

    // Transaction-level model: one request in flight at a time, a redirect
    // either restarts fetch at once or waits for the in-flight ack, and each
    // delivered word advances the fetch address unless the hazard holds it.
    task automatic test_random();
        int          k = 0;
        int          lat = 0;
        bit          known = 1'b0, outst = 1'b0, pend = 1'b0, busy = 1'b0;
        logic [31:0] exp_addr = RESET_PC, target = '0, rnd;
        logic        exp_req, deliver, exp_flush, exp_stall;
        logic [5:0]  exp_ctl;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst            = (n == 0) || ($urandom_range(0, 299) == 0);
            stall_hz       = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            rnd            = $urandom;
            redirect_pc    = rnd & 32'hFFFF_FFFC;
            exp_req        = 1'b0;
            if (k > int'(BOOT_CYCLES)) begin
                exp_req  = outst || !stall_hz;
                imem_ack = 1'b0;
                if (exp_req) begin
                    if (!busy) begin lat = $urandom_range(0, 3); busy = 1'b1; end
                    if (lat == 0) begin imem_ack = 1'b1; busy = 1'b0; end
                    else lat--;
                end
            end else begin
                imem_ack = 1'($urandom_range(0, 1));
            end
            #1;
            if (known && k <= int'(BOOT_CYCLES)) begin
                exp_ctl = (k < int'(BOOT_CYCLES)) ? 6'b100000 : 6'b001000;
                checks++; if ({ctl, pc_restore} !== {exp_ctl, RESET_PC}) begin errors++; $display("FAIL rnd_boot n=%0d: ctl=%b pc_restore=%h, want ctl=%b pc_restore=%h", n, ctl, pc_restore, exp_ctl, RESET_PC); end
            end else if (known) begin
                deliver   = imem_ack && !redirect_valid && !pend;
                exp_flush = (redirect_valid && (imem_ack || !exp_req)) || (imem_ack && pend);
                exp_stall = !exp_flush && (!imem_ack || (deliver && stall_hz));
                exp_ctl   = {1'b0, exp_req, exp_flush, exp_stall, deliver, 1'b1};
                checks++; if ({ctl, imem_addr} !== {exp_ctl, exp_addr}) begin errors++; $display("FAIL rnd_ctl n=%0d: ctl=%b addr=%h, want ctl=%b addr=%h", n, ctl, imem_addr, exp_ctl, exp_addr); end
                if (exp_flush) begin
                    checks++; if (pc_restore !== (redirect_valid ? redirect_pc : target)) begin errors++; $display("FAIL rnd_restore n=%0d: got %h want %h", n, pc_restore, redirect_valid ? redirect_pc : target); end
                end
                if (deliver) begin
                    checks++; if (instr_out !== mem_word(exp_addr)) begin errors++; $display("FAIL rnd_data n=%0d: got %h want %h", n, instr_out, mem_word(exp_addr)); end
                end
                checks++; if (pc_next !== pc_cur + PC_STEP) begin errors++; $display("FAIL rnd_pc_next n=%0d: got %h want %h", n, pc_next, pc_cur + PC_STEP); end
                if (exp_flush) begin
                    exp_addr = redirect_valid ? redirect_pc : target;
                    pend     = 1'b0;
                end else if (redirect_valid) begin
                    pend   = 1'b1;
                    target = redirect_pc;
                end else if (deliver && !stall_hz) begin
                    exp_addr = exp_addr + PC_STEP;
                end
                outst = exp_req && !imem_ack;
            end
            if (rst) begin
                known = 1'b1; k = 0; busy = 1'b0; outst = 1'b0; pend = 1'b0;
            end else if (known && k <= int'(BOOT_CYCLES)) begin
                k++;
                if (k > int'(BOOT_CYCLES)) begin
                    exp_addr = RESET_PC; outst = 1'b0; pend = 1'b0; busy = 1'b0;
                end
            end
        end
        @(negedge clk);
        rst = 1'b0; stall_hz = 1'b0; redirect_valid = 1'b0; imem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_delayed_ack();
        test_wait_redirect();
        test_stall();
        test_stall_redirect();
        test_pc_wrap();
        test_reset_in_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
